// File: rtl/nzcv_status_unit.sv
`default_nettype none
// ============================================================================
// Module      : nzcv_status_unit
// Description : Architectural NZCV flag holder for the condition-check stage.
//               Flag-setting EX results and direct (MSR-style) writes enter a
//               one-deep pending stage that drains into the committed flags
//               on the next edge. nzcv_fwd bypasses the pending stage so the
//               condition check always sees the newest flags. A bounded LIFO
//               saves flags on exception entry and restores them on return.
// Ports       :
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   stall, flush          block capture / kill the update currently in EX
//   upd_valid, upd_nzcv   ALU flag update {N,Z,C,V}
//   cond_pass             EX condition passed; gates upd_valid and msr_valid
//   msr_valid, msr_nzcv   direct flag write (wins over upd_valid)
//   save_req, restore_req push current flags / pop into committed flags
//   nzcv                  committed flags (registered)
//   nzcv_fwd              bypassed flags for the condition check
//   pend_valid            pending stage holds an uncommitted update
//   save_depth            occupied stack entries
//   stack_err             sticky overflow / underflow / conflict flag
// Revision    : 1.0 - initial release
// ============================================================================
module nzcv_status_unit #(
    parameter int SAVE_DEPTH = 2,
    parameter int DEPTH_W    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               flush,
    input  logic               upd_valid,
    input  logic [3:0]         upd_nzcv,
    input  logic               cond_pass,
    input  logic               msr_valid,
    input  logic [3:0]         msr_nzcv,
    input  logic               save_req,
    input  logic               restore_req,
    output logic [3:0]         nzcv,
    output logic [3:0]         nzcv_fwd,
    output logic               pend_valid,
    output logic [DEPTH_W-1:0] save_depth,
    output logic               stack_err
);

    localparam logic [1:0]         c_st_empty   = 2'd0;
    localparam logic [1:0]         c_st_partial = 2'd1;
    localparam logic [1:0]         c_st_full    = 2'd2;
    localparam logic [DEPTH_W-1:0] c_full_depth = DEPTH_W'(SAVE_DEPTH);
    localparam logic [DEPTH_W-1:0] c_one        = DEPTH_W'(1);

    logic [3:0]         r_nzcv;
    logic               r_pend_valid;
    logic [3:0]         r_pend_data;
    logic [1:0]         r_state;
    logic [DEPTH_W-1:0] r_depth;
    logic               r_err;
    logic [3:0]         r_stack [SAVE_DEPTH];

    logic [1:0]         w_state_next;
    logic [DEPTH_W-1:0] w_depth_next;
    logic               w_cap;
    logic [3:0]         w_cap_data;
    logic [3:0]         w_fwd;
    logic               w_push;
    logic               w_pop;
    logic               w_err;
    logic [3:0]         w_top;

    assign w_cap      = ~stall & ~flush & cond_pass & (upd_valid | msr_valid);
    assign w_cap_data = msr_valid ? msr_nzcv : upd_nzcv;
    assign w_fwd      = r_pend_valid ? r_pend_data : r_nzcv;

    // Simultaneous save and restore is treated as a conflict: neither acts.
    assign w_push = save_req & ~restore_req & (r_state != c_st_full);
    assign w_pop  = restore_req & ~save_req & (r_state != c_st_empty);
    assign w_err  = (save_req & restore_req)
                  | (save_req & ~restore_req & (r_state == c_st_full))
                  | (restore_req & ~save_req & (r_state == c_st_empty));

    // Top-of-stack is the entry just below the current depth.
    always_comb begin
        w_top = 4'd0;
        for (int i = 0; i < SAVE_DEPTH; i++) begin
            if (r_depth == DEPTH_W'(i + 1)) begin
                w_top = r_stack[i];
            end
        end
    end

    // Depth FSM: next state and next depth.
    always_comb begin
        w_state_next = r_state;
        w_depth_next = r_depth;
        if (w_push) begin
            w_depth_next = r_depth + c_one;
        end else if (w_pop) begin
            w_depth_next = r_depth - c_one;
        end
        case (r_state)
            c_st_empty: begin
                if (w_push) begin
                    w_state_next = (c_full_depth == c_one) ? c_st_full : c_st_partial;
                end
            end
            c_st_partial: begin
                if (w_push && (r_depth + c_one == c_full_depth)) begin
                    w_state_next = c_st_full;
                end else if (w_pop && (r_depth == c_one)) begin
                    w_state_next = c_st_empty;
                end
            end
            c_st_full: begin
                if (w_pop) begin
                    w_state_next = (c_full_depth == c_one) ? c_st_empty : c_st_partial;
                end
            end
            default: begin
                w_state_next = c_st_empty;
                w_depth_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_empty;
            r_depth <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_depth <= w_depth_next;
            if (w_err) begin
                r_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SAVE_DEPTH; i++) begin
                r_stack[i] <= 4'd0;
            end
        end else if (w_push) begin
            // The pushed value is the bypassed flags, so an update still in
            // the pending stage is saved rather than the stale committed copy.
            for (int i = 0; i < SAVE_DEPTH; i++) begin
                if (r_depth == DEPTH_W'(i)) begin
                    r_stack[i] <= w_fwd;
                end
            end
        end
    end

    // Pending stage and committed flags. A pop overrides everything: it wins
    // the committed register and discards both the pending entry and any
    // capture in the same cycle. A pending entry otherwise always commits,
    // stall and flush only gate new captures.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nzcv       <= 4'd0;
            r_pend_valid <= 1'b0;
            r_pend_data  <= 4'd0;
        end else begin
            if (w_pop) begin
                r_nzcv       <= w_top;
                r_pend_valid <= 1'b0;
            end else begin
                if (r_pend_valid) begin
                    r_nzcv <= r_pend_data;
                end
                r_pend_valid <= w_cap;
                if (w_cap) begin
                    r_pend_data <= w_cap_data;
                end
            end
        end
    end

    assign nzcv       = r_nzcv;
    assign nzcv_fwd   = w_fwd;
    assign pend_valid = r_pend_valid;
    assign save_depth = r_depth;
    assign stack_err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_nzcv_status_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_nzcv_status_unit
// Description : Self-checking bench for nzcv_status_unit. Directed scenarios
//               with constant expectations, plus randomized traffic compared
//               each cycle against a flag/queue reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nzcv_status_unit;

    localparam int SAVE_DEPTH = 2;
    localparam int DEPTH_W    = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               stall, flush, upd_valid, cond_pass, msr_valid;
    logic [3:0]         upd_nzcv, msr_nzcv;
    logic               save_req, restore_req;
    logic [3:0]         nzcv, nzcv_fwd;
    logic               pend_valid;
    logic [DEPTH_W-1:0] save_depth;
    logic               stack_err;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [3:0] m_nz;
    logic       m_pv;
    logic [3:0] m_pd;
    logic       m_err;
    logic [3:0] m_stack[$];

    nzcv_status_unit #(.SAVE_DEPTH(SAVE_DEPTH), .DEPTH_W(DEPTH_W)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .upd_valid(upd_valid), .upd_nzcv(upd_nzcv), .cond_pass(cond_pass),
        .msr_valid(msr_valid), .msr_nzcv(msr_nzcv), .save_req(save_req),
        .restore_req(restore_req), .nzcv(nzcv), .nzcv_fwd(nzcv_fwd),
        .pend_valid(pend_valid), .save_depth(save_depth), .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        stall = 0; flush = 0; upd_valid = 0; cond_pass = 1; msr_valid = 0;
        upd_nzcv = 0; msr_nzcv = 0; save_req = 0; restore_req = 0;
    endtask

    task automatic model_reset();
        m_nz = 0; m_pv = 0; m_pd = 0; m_err = 0;
        m_stack.delete();
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 0;
        model_reset();
        @(negedge clk);
        rst_n = 1;
    endtask

    // One clock: advance the model from the inputs seen at the edge.
    task automatic step();
        logic [3:0] fwd, nz_n;
        logic cap, popped;
        @(posedge clk);
        fwd    = m_pv ? m_pd : m_nz;
        cap    = !stall && !flush && cond_pass && (upd_valid || msr_valid);
        popped = 0;
        nz_n   = m_nz;
        if (save_req && restore_req) m_err = 1;
        else if (save_req) begin
            if (m_stack.size() == SAVE_DEPTH) m_err = 1;
            else m_stack.push_back(fwd);
        end else if (restore_req) begin
            if (m_stack.size() == 0) m_err = 1;
            else begin
                nz_n   = m_stack.pop_back();
                popped = 1;
            end
        end
        if (popped) begin
            m_pv = 0;
        end else begin
            if (m_pv) nz_n = m_pd;
            if (cap) m_pd = msr_valid ? msr_nzcv : upd_nzcv;
            m_pv = cap;
        end
        m_nz = nz_n;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        clear_inputs();
        model_reset();
        #1;
        tests++;
        if ({nzcv, nzcv_fwd, pend_valid, save_depth, stack_err} !== '0) begin
            fails++;
            $display("FAIL reset: got nz=%b fwd=%b pv=%b d=%0d err=%b, want all 0",
                     nzcv, nzcv_fwd, pend_valid, save_depth, stack_err);
        end
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_latency();
        do_reset();
        upd_valid = 1; upd_nzcv = 4'b0100;
        step();
        clear_inputs();
        tests++;
        if (nzcv_fwd !== 4'b0100 || pend_valid !== 1'b1 || nzcv !== 4'b0000) begin
            fails++;
            $display("FAIL lat_t1: got fwd=%b pv=%b nz=%b, want 0100 1 0000", nzcv_fwd, pend_valid, nzcv);
        end
        step();
        tests++;
        if (nzcv !== 4'b0100 || pend_valid !== 1'b0) begin
            fails++;
            $display("FAIL lat_t2: got nz=%b pv=%b, want 0100 0", nzcv, pend_valid);
        end
    endtask

    task automatic test_gating();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            clear_inputs();
            upd_valid = 1; upd_nzcv = 4'b1111;
            if (k == 0) cond_pass = 0;
            if (k == 1) flush = 1;
            if (k == 2) stall = 1;
            step();
            tests++;
            if (nzcv !== 4'b0000 || nzcv_fwd !== 4'b0000 || pend_valid !== 1'b0) begin
                fails++;
                $display("FAIL gate_%0d: got nz=%b fwd=%b pv=%b, want 0000 0000 0", k, nzcv, nzcv_fwd, pend_valid);
            end
        end
        clear_inputs();
    endtask

    task automatic test_msr_stall();
        do_reset();
        msr_valid = 1; msr_nzcv = 4'b1001; upd_valid = 1; upd_nzcv = 4'b0110;
        step();
        clear_inputs();
        tests++;
        if (nzcv_fwd !== 4'b1001) begin
            fails++;
            $display("FAIL msr_prio: got fwd=%b, want 1001", nzcv_fwd);
        end
        step();
        upd_valid = 1; upd_nzcv = 4'b0010;
        step();
        stall = 1; upd_nzcv = 4'b0111;
        tests++;
        if (nzcv_fwd !== 4'b0010 || pend_valid !== 1'b1) begin
            fails++;
            $display("FAIL stall_t1: got fwd=%b pv=%b, want 0010 1", nzcv_fwd, pend_valid);
        end
        step();
        clear_inputs();
        tests++;
        if (nzcv !== 4'b0010 || pend_valid !== 1'b0 || nzcv_fwd !== 4'b0010) begin
            fails++;
            $display("FAIL stall_t2: got nz=%b pv=%b fwd=%b, want 0010 0 0010", nzcv, pend_valid, nzcv_fwd);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] vals [3];
        vals[0] = 4'b0001; vals[1] = 4'b0010; vals[2] = 4'b0011;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            upd_valid = 1; upd_nzcv = vals[k];
            step();
            tests++;
            if (nzcv_fwd !== vals[k] || pend_valid !== 1'b1) begin
                fails++;
                $display("FAIL b2b_%0d: got fwd=%b pv=%b, want %b 1", k, nzcv_fwd, pend_valid, vals[k]);
            end
        end
        clear_inputs();
        step();
        tests++;
        if (nzcv !== 4'b0011 || pend_valid !== 1'b0) begin
            fails++;
            $display("FAIL b2b_last: got nz=%b pv=%b, want 0011 0", nzcv, pend_valid);
        end
    endtask

    task automatic test_stack();
        do_reset();
        upd_valid = 1; upd_nzcv = 4'b1000; step(); clear_inputs(); step();
        save_req = 1; step(); clear_inputs();
        tests++;
        if (save_depth !== 2'd1 || nzcv !== 4'b1000) begin
            fails++;
            $display("FAIL stk_push1: got d=%0d nz=%b, want 1 1000", save_depth, nzcv);
        end
        upd_valid = 1; upd_nzcv = 4'b0001; step(); clear_inputs(); step();
        save_req = 1; step();
        tests++;
        if (save_depth !== 2'd2 || stack_err !== 1'b0) begin
            fails++;
            $display("FAIL stk_push2: got d=%0d err=%b, want 2 0", save_depth, stack_err);
        end
        step(); clear_inputs();
        tests++;
        if (save_depth !== 2'd2 || stack_err !== 1'b1) begin
            fails++;
            $display("FAIL stk_over: got d=%0d err=%b, want 2 1", save_depth, stack_err);
        end
        // Overwrite committed flags so the first pop is observable.
        upd_valid = 1; upd_nzcv = 4'b0110; step(); clear_inputs(); step();
        restore_req = 1; step();
        tests++;
        if (nzcv !== 4'b0001 || save_depth !== 2'd1) begin
            fails++;
            $display("FAIL stk_pop1: got nz=%b d=%0d, want 0001 1", nzcv, save_depth);
        end
        step(); clear_inputs();
        tests++;
        if (nzcv !== 4'b1000 || save_depth !== 2'd0) begin
            fails++;
            $display("FAIL stk_pop2: got nz=%b d=%0d, want 1000 0", nzcv, save_depth);
        end
    endtask

    task automatic test_restore_priority();
        do_reset();
        upd_valid = 1; upd_nzcv = 4'b1010; step(); clear_inputs(); step();
        save_req = 1; step(); clear_inputs();
        upd_valid = 1; upd_nzcv = 4'b0100; step(); clear_inputs();
        // Pop while 0100 is pending, with a fresh capture also presented.
        restore_req = 1; upd_valid = 1; upd_nzcv = 4'b0111;
        step(); clear_inputs();
        tests++;
        if (nzcv !== 4'b1010 || pend_valid !== 1'b0 || nzcv_fwd !== 4'b1010 || save_depth !== 2'd0) begin
            fails++;
            $display("FAIL rst_prio: got nz=%b pv=%b fwd=%b d=%0d, want 1010 0 1010 0",
                     nzcv, pend_valid, nzcv_fwd, save_depth);
        end
        restore_req = 1; step(); clear_inputs();
        tests++;
        if (stack_err !== 1'b1 || nzcv !== 4'b1010 || save_depth !== 2'd0) begin
            fails++;
            $display("FAIL under: got err=%b nz=%b d=%0d, want 1 1010 0", stack_err, nzcv, save_depth);
        end
        save_req = 1; restore_req = 1; step(); clear_inputs();
        tests++;
        if (save_depth !== 2'd0 || nzcv !== 4'b1010) begin
            fails++;
            $display("FAIL conflict: got d=%0d nz=%b, want 0 1010", save_depth, nzcv);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        upd_valid = 1; upd_nzcv = 4'b0011; step(); clear_inputs(); step();
        save_req = 1; step(); step(); clear_inputs();
        upd_valid = 1; upd_nzcv = 4'b0101; step(); clear_inputs();
        tests++;
        if (pend_valid !== 1'b1 || save_depth !== 2'd2) begin
            fails++;
            $display("FAIL ares_pre: got pv=%b d=%0d, want 1 2", pend_valid, save_depth);
        end
        #2;
        rst_n = 0;
        model_reset();
        #1;
        tests++;
        if ({nzcv, nzcv_fwd, pend_valid, save_depth, stack_err} !== '0) begin
            fails++;
            $display("FAIL ares: got nz=%b fwd=%b pv=%b d=%0d err=%b, want all 0",
                     nzcv, nzcv_fwd, pend_valid, save_depth, stack_err);
        end
        @(negedge clk);
        rst_n = 1;
        upd_valid = 1; upd_nzcv = 4'b0100; step(); clear_inputs();
        tests++;
        if (nzcv_fwd !== 4'b0100 || pend_valid !== 1'b1 || nzcv !== 4'b0000) begin
            fails++;
            $display("FAIL ares_t1: got fwd=%b pv=%b nz=%b, want 0100 1 0000", nzcv_fwd, pend_valid, nzcv);
        end
        step();
        tests++;
        if (nzcv !== 4'b0100 || pend_valid !== 1'b0) begin
            fails++;
            $display("FAIL ares_t2: got nz=%b pv=%b, want 0100 0", nzcv, pend_valid);
        end
    endtask

    task automatic test_random();
        logic [3:0] exp_fwd;
        do_reset();
        for (int n = 0; n < 500; n++) begin
            stall       = ($urandom_range(0, 4) == 0);
            flush       = ($urandom_range(0, 5) == 0);
            upd_valid   = $urandom_range(0, 1);
            cond_pass   = ($urandom_range(0, 4) != 0);
            msr_valid   = ($urandom_range(0, 4) == 0);
            upd_nzcv    = 4'($urandom);
            msr_nzcv    = 4'($urandom);
            save_req    = ($urandom_range(0, 6) == 0);
            restore_req = ($urandom_range(0, 6) == 0);
            if (n == 250) begin
                do_reset();
            end else begin
                step();
                exp_fwd = m_pv ? m_pd : m_nz;
                tests++;
                if (nzcv !== m_nz || nzcv_fwd !== exp_fwd || pend_valid !== m_pv ||
                    save_depth !== DEPTH_W'(m_stack.size()) || stack_err !== m_err) begin
                    fails++;
                    $display("FAIL rand_%0d: got nz=%b fwd=%b pv=%b d=%0d err=%b, want %b %b %b %0d %b",
                             n, nzcv, nzcv_fwd, pend_valid, save_depth, stack_err,
                             m_nz, exp_fwd, m_pv, m_stack.size(), m_err);
                end
            end
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rst_n = 0;
        test_reset();
        test_latency();
        test_gating();
        test_msr_stall();
        test_back_to_back();
        test_stack();
        test_restore_priority();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nzcv_status_unit.md
Name: nzcv_status_unit

Overview:
Holds the architectural NZCV status flags and supplies them to the condition-check stage, which sits directly downstream. Flag-setting instructions in EX, and MSR-style direct writes, enter a one-deep pending stage. A bypass path keeps the condition check current while that pending stage drains into the committed register. A bounded save/restore stack preserves the flags across exception entry and return.

Parameters:
SAVE_DEPTH, 2, number of entries in the flag save stack (must be ≥1).
DEPTH_W, 2, width of the save_depth output; must satisfy 2^DEPTH_W > SAVE_DEPTH.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
stall  input  1  pipeline stall; blocks capture of new updates.
flush  input  1  kills the update currently presented in EX.
upd_valid  input  1  EX instruction has the S bit set and writes flags.
upd_nzcv  input  4  ALU flags {N,Z,C,V}; bit3=N, bit2=Z, bit1=C, bit0=V.
cond_pass  input  1  the EX instruction's condition passed; gates upd_valid and msr_valid.
msr_valid  input  1  direct flag write request.
msr_nzcv  input  4  data for the direct flag write.
save_req  input  1  push the current flags (exception entry).
restore_req  input  1  pop flags into the committed register (exception return).
nzcv  output  4  committed flags; registered.
nzcv_fwd  output  4  bypassed flags; this is the condition-check input.
pend_valid  output  1  the pending stage holds an uncommitted update.
save_depth  output  DEPTH_W  number of occupied stack entries.
stack_err  output  1  sticky overflow/underflow/conflict error flag.

Behaviour:
- Reset (async, rst_n=0):
  - nzcv=0, pend_valid=0, pending data=0.
  - save_depth=0, stack_err=0, all stack entries=0.
  - Reset takes effect immediately, mid-operation included; nothing in flight survives.
- Capture (each rising edge):
  - Define cap = !stall & !flush & cond_pass & (upd_valid | msr_valid).
  - pend_valid <= cap.
  - Pending data <= msr_nzcv if msr_valid, else upd_nzcv. msr_valid wins when both requests are asserted.
- Commit: if pend_valid=1 at an edge, nzcv <= pending data. This happens regardless of stall or flush, because a pending entry is past the commit point.
- Forwarding: nzcv_fwd = pend_valid ? pending data : nzcv (combinational).
- Latency:
  - An update presented in cycle T is visible on nzcv_fwd in T+1 and on nzcv in T+2.
  - Back-to-back updates on consecutive cycles each pass through the pending stage; the last one wins.
- Stall: no new capture. An existing pending entry still commits, then pend_valid drops to 0. Stall does not block save or restore.
- Flush: only the current EX update is discarded. The pending entry and the stack are unaffected.
- Save stack: a LIFO of SAVE_DEPTH 4-bit entries. The depth FSM has states EMPTY (depth 0), PARTIAL (0<depth<SAVE_DEPTH) and FULL (depth=SAVE_DEPTH).
- save_req alone:
  - Not FULL: push the nzcv_fwd value sampled this cycle; depth+1.
  - FULL: ignore the push and set stack_err.
- restore_req alone:
  - Not EMPTY: nzcv <= top entry and depth-1. The pending entry and any capture this cycle are discarded, so pend_valid <= 0. Restore has the highest priority on nzcv.
  - EMPTY: ignore the restore, set stack_err, and handle capture/commit normally.
- save_req and restore_req together: both are ignored, stack_err is set, and capture/commit proceed normally.
- stack_err is sticky; only reset clears it.
- Depth is saturating: it never wraps past SAVE_DEPTH and never goes below 0.

Test Plan:
1. Reset, then upd_valid=1, cond_pass=1, upd_nzcv=4'b0100 in cycle T → nzcv_fwd=0100 at T+1 with pend_valid=1; nzcv=0100 at T+2; pend_valid=0 at T+2.
2. upd_valid=1 with cond_pass=0; then the same with flush=1; then the same with stall=1 → nzcv and nzcv_fwd stay 0000, pend_valid stays 0.
3. msr_valid=1 with msr_nzcv=1001, together with upd_valid=1 with upd_nzcv=0110 → nzcv_fwd=1001 next cycle. Then update 0010 in T and stall=1 in T+1 → nzcv=0010 at T+2.
4. nzcv=1000, save_req → depth=1. Update to 0001. save_req → depth=2. Another save_req → depth stays 2 and stack_err=1. restore_req → nzcv=0001, depth=1. restore_req → nzcv=1000, depth=0.
5. A pending update of 0100 is present when restore_req pops 1010 → nzcv=1010 and pend_valid=0. Then restore_req on EMPTY → stack_err=1 and nzcv unchanged.
6. Assert rst_n=0 asynchronously between edges while pend_valid=1 and depth=2 → all outputs go to 0 immediately; after release, the first update behaves as in scenario 1.
